img_stream_checker: RTL and testbench

Parametrised on-chip frame checker for the SIFT pipeline. It replaces per-layer pixel-by-pixel comparison of Gaussian-blur outputs against golden images. It consumes CH parallel pixel lanes from the DUT (one lane per blur layer) and a matching golden stream. Per pixel it compares each lane within a programmable tolerance, then reports per-lane mismatch counts, the first failing coordinate and a pass flag at end of frame. It sits between the blur-layer read-out path and the debug/status register bank.

---
 rtl/img_stream_checker.sv | 157 +++++++++++++++
 tb/tb_img_stream_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_checker.sv
// img_stream_checker
//   On-chip frame checker: compares CH parallel pixel lanes from the DUT
//   against a golden stream within tolerance TOL. It reports per-lane
//   saturating mismatch counts, the first failing coordinate and lane, and
//   a pass flag at end of frame.
//
//   Optional build macro: IMG_STREAM_CHK_MAXERR_EN adds the max_err output,
//   which holds the per-lane running maximum absolute difference.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 one-cycle pulse, (re)arms for a new frame
//   act_valid/data/ready  DUT pixel stream (CH lanes of PIX_W bits)
//   exp_valid/data/ready  golden pixel stream
//   busy                  frame in progress
//   done                  frame complete, held until start or reset
//   pass                  done and no lane mismatched
//   err_cnt               CH x ERR_W saturating mismatch counters
//   first_err_*           coordinate and lowest lane of first mismatch
//   max_err               (optional) per-lane running max |act - exp|
module img_stream_checker #(
  parameter int PIX_W = 8,
  parameter int COLS  = 640,
  parameter int ROWS  = 480,
  parameter int CH    = 4,
  parameter int TOL   = 0,
  parameter int ERR_W = 20,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                act_valid,
  input  logic [CH*PIX_W-1:0] act_data,
  output logic                act_ready,
  input  logic                exp_valid,
  input  logic [CH*PIX_W-1:0] exp_data,
  output logic                exp_ready,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CH*ERR_W-1:0] err_cnt,
  output logic                first_err_vld,
  output logic [ROW_W-1:0]    first_err_row,
  output logic [COL_W-1:0]    first_err_col,
  output logic [CH_W-1:0]     first_err_ch
`ifdef IMG_STREAM_CHK_MAXERR_EN
  ,
  output logic [CH*PIX_W-1:0] max_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             run;
  logic             xfer;
  logic             last;
  logic [PIX_W:0]   diff [CH];
  logic [CH-1:0]    mism;
  logic [CH_W-1:0]  low_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // start takes priority over a coincident valid pair, so the readies are
  // gated with it to keep the handshake honest on both sides.
  always_comb begin
    state_nxt = state;
    run       = (state == RUN);
    xfer      = run & act_valid & exp_valid & ~start;
    last      = xfer && (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));
    act_ready = run & exp_valid & ~start;
    exp_ready = run & act_valid & ~start;
    busy      = run;
    done      = (state == DONE);
    pass      = (state == DONE) && (err_cnt == '0);
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (start) state_nxt = RUN;
               else if (last) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Differences are formed one bit wider so |a - b| never wraps.
  always_comb begin
    mism   = '0;
    low_ch = '0;
    for (int k = 0; k < CH; k++) begin
      if (act_data[k*PIX_W +: PIX_W] >= exp_data[k*PIX_W +: PIX_W])
        diff[k] = {1'b0, act_data[k*PIX_W +: PIX_W]} - {1'b0, exp_data[k*PIX_W +: PIX_W]};
      else
        diff[k] = {1'b0, exp_data[k*PIX_W +: PIX_W]} - {1'b0, act_data[k*PIX_W +: PIX_W]};
      mism[k] = (diff[k] > (PIX_W+1)'(TOL));
    end
    for (int k = CH - 1; k >= 0; k--) begin
      if (mism[k]) low_ch = CH_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row           <= '0;
      col           <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_row <= '0;
      first_err_col <= '0;
      first_err_ch  <= '0;
`ifdef IMG_STREAM_CHK_MAXERR_EN
      max_err       <= '0;
`endif
    end else if (start) begin
      row           <= '0;
      col           <= '0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_row <= '0;
      first_err_col <= '0;
      first_err_ch  <= '0;
`ifdef IMG_STREAM_CHK_MAXERR_EN
      max_err       <= '0;
`endif
    end else if (xfer) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      for (int k = 0; k < CH; k++) begin
        if (mism[k] && (err_cnt[k*ERR_W +: ERR_W] != {ERR_W{1'b1}}))
          err_cnt[k*ERR_W +: ERR_W] <= err_cnt[k*ERR_W +: ERR_W] + 1'b1;
`ifdef IMG_STREAM_CHK_MAXERR_EN
        // diff never exceeds 2^PIX_W-1, so the low PIX_W bits are exact.
        if (diff[k][PIX_W-1:0] > max_err[k*PIX_W +: PIX_W])
          max_err[k*PIX_W +: PIX_W] <= diff[k][PIX_W-1:0];
`endif
      end
      if ((mism != '0) && !first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_row <= row;
        first_err_col <= col;
        first_err_ch  <= low_ch;
      end
    end
  end

endmodule

// File: tb/tb_img_stream_checker.sv
module tb_img_stream_checker;

  localparam int PIX_W = 8, COLS = 4, ROWS = 3, CH = 2, TOL = 1, ERR_W = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, act_valid, exp_valid;
  logic [15:0] act_data, exp_data;
  logic        act_ready, exp_ready, busy, done, pass, first_err_vld;
  logic [7:0]  err_cnt;
  logic [1:0]  first_err_row, first_err_col;
  logic        first_err_ch;
  logic        d3_ar, d3_er, d3_busy, d3_done, d3_pass, d3_fv, d3_fch;
  logic [5:0]  err_cnt3;
  logic [1:0]  d3_frow, d3_fcol;
`ifdef IMG_STREAM_CHK_MAXERR_EN
  logic [15:0] max_err, d3_max;
`endif

  always #5 clk = ~clk;

  img_stream_checker #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .CH(CH), .TOL(TOL), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vld(first_err_vld), .first_err_row(first_err_row),
    .first_err_col(first_err_col), .first_err_ch(first_err_ch)
`ifdef IMG_STREAM_CHK_MAXERR_EN
    , .max_err(max_err)
`endif
  );

  // Same stimulus into a 3-bit-counter instance to observe saturation.
  img_stream_checker #(.PIX_W(PIX_W), .COLS(COLS), .ROWS(ROWS), .CH(CH), .TOL(TOL), .ERR_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .act_valid(act_valid), .act_data(act_data), .act_ready(d3_ar),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(d3_er),
    .busy(d3_busy), .done(d3_done), .pass(d3_pass), .err_cnt(err_cnt3),
    .first_err_vld(d3_fv), .first_err_row(d3_frow),
    .first_err_col(d3_fcol), .first_err_ch(d3_fch)
`ifdef IMG_STREAM_CHK_MAXERR_EN
    , .max_err(d3_max)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       pass;
    logic       fvld;
    logic [1:0] frow;
    logic [1:0] fcol;
    logic       fch;
    logic [7:0] err;
    logic [5:0] err3;
  } frame_t;

  logic [13:0] xq[$];   // expected {err_cnt, err_cnt3} after each transfer
  frame_t      fq[$];   // expected end-of-frame results

  // Reference model state
  bit m_run, m_done, m_fvld;
  int m_row, m_col, m_frow, m_fcol, m_fch;
  int m_e4[2], m_e3[2], m_max[2];

  task automatic model_clear();
    m_row = 0; m_col = 0; m_fvld = 0; m_frow = 0; m_fcol = 0; m_fch = 0;
    for (int k = 0; k < 2; k++) begin m_e4[k] = 0; m_e3[k] = 0; m_max[k] = 0; end
  endtask

  task automatic step(input bit st, input bit av, input bit ev,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] a0, input logic [7:0] a1);
    bit xfer;
    int d[2];
    bit mm[2];
    frame_t f;
    logic [13:0] xe;
    start = st; act_valid = av; exp_valid = ev;
    act_data = {a1, a0}; exp_data = {e1, e0};
    #1;
    if (!st) begin
      chk("act_ready", act_ready, m_run & ev);
      chk("exp_ready", exp_ready, m_run & av);
    end
    @(posedge clk);
    #1;
    xfer = m_run && av && ev && !st;
    if (st) begin
      m_run = 1; m_done = 0; model_clear();
    end else if (xfer) begin
      d[0] = (a0 > e0) ? int'(a0) - int'(e0) : int'(e0) - int'(a0);
      d[1] = (a1 > e1) ? int'(a1) - int'(e1) : int'(e1) - int'(a1);
      for (int k = 0; k < 2; k++) begin
        mm[k] = d[k] > TOL;
        if (mm[k] && m_e4[k] < 15) m_e4[k]++;
        if (mm[k] && m_e3[k] < 7) m_e3[k]++;
        if (d[k] > m_max[k]) m_max[k] = d[k];
      end
      if ((mm[0] || mm[1]) && !m_fvld) begin
        m_fvld = 1; m_frow = m_row; m_fcol = m_col; m_fch = mm[0] ? 0 : 1;
      end
      xq.push_back({4'(m_e4[1]), 4'(m_e4[0]), 3'(m_e3[1]), 3'(m_e3[0])});
      if (m_row == ROWS - 1 && m_col == COLS - 1) begin
        m_run = 0; m_done = 1;
        f.pass = (m_e4[0] == 0) && (m_e4[1] == 0);
        f.fvld = m_fvld; f.frow = 2'(m_frow); f.fcol = 2'(m_fcol); f.fch = 1'(m_fch);
        f.err  = {4'(m_e4[1]), 4'(m_e4[0])};
        f.err3 = {3'(m_e3[1]), 3'(m_e3[0])};
        fq.push_back(f);
      end
      if (m_col == COLS - 1) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
      else m_col++;
    end
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("first_err_vld", first_err_vld, m_fvld);
`ifdef IMG_STREAM_CHK_MAXERR_EN
    chk("max_err", max_err, {8'(m_max[1]), 8'(m_max[0])});
`endif
    if (xfer && xq.size() > 0) begin
      xe = xq.pop_front();
      chk("err_cnt_xfer", {err_cnt, err_cnt3}, xe);
    end
    if (done && fq.size() > 0) begin
      f = fq.pop_front();
      chk("pass", pass, f.pass);
      chk("err_cnt_frame", err_cnt, f.err);
      chk("err_cnt3_frame", err_cnt3, f.err3);
      chk("first_err", {first_err_vld, first_err_row, first_err_col, first_err_ch},
          {f.fvld, f.frow, f.fcol, f.fch});
    end
  endtask

  task automatic px(input bit st, input bit av, input bit ev, input int off0, input int off1);
    logic [7:0] e0, e1;
    e0 = 8'($urandom_range(10, 240));
    e1 = 8'($urandom_range(10, 240));
    step(st, av, ev, e0, e1, 8'(int'(e0) + off0), 8'(int'(e1) + off1));
  endtask

  task automatic idle();
    step(0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    int busy_cycles;
    rst_n = 1'b0; start = 0; act_valid = 1; exp_valid = 1; act_data = 0; exp_data = 0;
    m_run = 0; m_done = 0; model_clear();
    #12;
    // reset state
    chk("rst_outputs", {act_ready, exp_ready, busy, done, pass, err_cnt, first_err_vld,
                        first_err_row, first_err_col, first_err_ch}, 17'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle();

    // identical streams
    px(1, 0, 0, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_cycles++;
      px(0, 1, 1, 0, 0);
    end
    chk("busy_cycles", busy_cycles, 12);
    chk("pass_identical", pass, 1'b1);
    idle(); idle();
    chk("done_held", done, 1'b1);

    // single pixel off at (1,2): lane1 by 2, lane0 by 1 (within tolerance)
    px(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) px(0, 1, 1, (i == 6) ? 1 : 0, (i == 6) ? 2 : 0);
    chk("t2_err_cnt", err_cnt, 8'h10);
    chk("t2_first", {first_err_row, first_err_col, first_err_ch}, {2'd1, 2'd2, 1'b1});
    chk("t2_pass", pass, 1'b0);

    // all off by 5, twice: counter 12, saturating 3-bit copy at 7
    for (int f = 0; f < 2; f++) begin
      px(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) px(0, 1, 1, 5, -5);
      chk("t3_err_cnt", err_cnt, 8'hCC);
      chk("t3_err_cnt3", err_cnt3, 6'o77);
    end

    // exp_valid toggles, act_valid held high
    px(1, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) px(0, 1, (i % 2) == 1, 0, 3);
    chk("t4_done", done, 1'b1);
    chk("t4_err_cnt", err_cnt, 8'hC0);

    // restart coincident with a valid pair after 5 transfers
    px(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) px(0, 1, 1, 4, 0);
    px(1, 1, 1, 4, 4);
    chk("t5_cleared", {err_cnt, first_err_vld}, 9'd0);
    for (int i = 0; i < 11; i++) px(0, 1, 1, 0, 0);
    chk("t5_not_done", done, 1'b0);
    px(0, 1, 1, 0, 0);
    chk("t5_done", {done, pass}, 2'b11);

    // async reset mid-frame
    px(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) px(0, 1, 1, 5, 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {act_ready, exp_ready, busy, done, pass, err_cnt, first_err_vld,
                           first_err_row, first_err_col, first_err_ch}, 17'd0);
    m_run = 0; m_done = 0; model_clear();
    @(posedge clk); #1; rst_n = 1'b1;
    xq.delete();
    idle();
    chk("midrst_idle", busy, 1'b0);
    px(1, 0, 0, 0, 0);
    px(0, 1, 1, 0, 0);
    px(0, 1, 1, 3, 0);
    px(0, 1, 1, -1, 0);
`ifdef IMG_STREAM_CHK_MAXERR_EN
    chk("max_err_lane0", max_err[7:0], 8'd3);
`endif
    chk("post_rst_err", err_cnt, 8'h01);
    for (int i = 0; i < 9; i++) px(0, 1, 1, 0, 0);
    idle();
    chk("frames_all_seen", fq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
